fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Round-robin, burst-capable arbiter that shares the single push port of one sync_fifo among NUM_REQ producers.
- Each producer presents a request with its data word and holds both until granted.
- The arbiter selects one producer, drives the FIFO push request and data directly, and never pushes into a full FIFO.
- Sits between the producer blocks and sync_fifo's push_req_in / data_in / full_out.

Parameters:
- NUM_REQ, 4: number of producers; must be 2..16.
- DATA_WIDTH, 16: data word width; must match the sync_fifo DATA_WIDTH.
- MAX_BURST, 4: maximum consecutive beats granted to one owner before re-arbitration; must be 1..255.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- req_in  in  NUM_REQ  per-producer request; bit i is producer i.
- data_in  in  NUM_REQ*DATA_WIDTH  packed data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt_out  out  NUM_REQ  one-hot grant; a beat is accepted in the cycle it is high.
- fifo_push_req_out  out  1  drives sync_fifo push_req_in.
- fifo_data_out  out  DATA_WIDTH  drives sync_fifo data_in.
- fifo_full_in  in  1  from sync_fifo full_out.
- owner_out  out  $clog2(NUM_REQ)  current or most recent owner index.
- busy_out  out  1  high while the arbiter is in BURST state.
- stall_clr_in  in  1  synchronous clear for stall_cnt_out.
- stall_cnt_out  out  16  saturating count of stalled cycles.

Behaviour:
- Registers:
  - state: IDLE or BURST.
  - ptr: round-robin start index.
  - owner: current owner index.
  - beat_cnt: 8-bit beat counter.
  - stall_cnt: 16-bit stall counter.
- Reset, asynchronous while rstn is low:
  - state=IDLE, ptr=0, owner=0, beat_cnt=0, stall_cnt=0.
  - gnt_out, fifo_push_req_out and fifo_data_out are forced to 0 combinationally.
  - owner_out=0, busy_out=0.
  - Reset asserted mid-burst aborts the burst immediately; no partial beat is pushed.
- open = (state==IDLE) | ~req_in[owner] | (beat_cnt==MAX_BURST).
- Winner: the first set bit of req_in searching ptr, ptr+1, … with wrap modulo NUM_REQ.
- Grant, combinational, zero latency:
  - If open & |req_in & ~fifo_full_in: gnt_out = onehot(winner).
  - If ~open & ~fifo_full_in: gnt_out = onehot(owner). Here req_in[owner]=1 by construction.
  - Otherwise gnt_out=0.
- FIFO outputs:
  - fifo_push_req_out = |gnt_out.
  - fifo_data_out = granted producer's slice, or 0 when there is no grant.
- Next state on a new grant from open: state=BURST, owner=winner, beat_cnt=1, ptr=(winner+1) mod NUM_REQ.
- Next state on an owner continuation grant: beat_cnt+1; owner and ptr are unchanged.
- Next state when open and there is no grant (no requests, or FIFO full): state=IDLE; owner, ptr and beat_cnt are held.
- Next state when ~open and fifo_full_in: hold all state. The owner keeps the lock and no other producer is granted.
- No bubble on re-arbitration: the cycle after a burst ends or the owner drops its request can grant a new winner, including the same producer again.
- Invariant: fifo_push_req_out is never 1 while fifo_full_in=1. As a result, sync_fifo error_out is never set by this block.
- owner_out = owner; busy_out = (state==BURST).
- stall_cnt:
  - stall_clr_in=1 → 0; clear has priority over increment.
  - Else if |req_in & fifo_full_in → +1, saturating at 16'hFFFF.

Test Plan:
- Reset: assert rstn=0 mid-burst with req_in=4'hF → all outputs 0 in the same cycle. After release, the first grant goes to producer 0.
- Single producer: req_in=4'b0001, data 0x100,0x101,… held per beat, FIFO not full → push every cycle. beat_cnt follows 1,2,3,4,1,…; no bubble. Data 0x100..0x107 lands in the FIFO in order.
- Full rotation: req_in=4'hF continuous, pops disabled, FIFO DEPTH 16.
  - Grants are 0×4, 1×4, 2×4, 3×4.
  - After 16 pushes, full=1 and gnt_out=0.
  - stall_cnt increments each cycle.
  - sync_fifo error_out stays 0.
- Pointer wrap: with ptr=2 and req_in=4'b1010 → producer 3 is granted first, ptr becomes 0, then producer 1 is granted.
- Early release: producer 0 drops req after 2 beats while req_in[2]=1 → producer 2 is granted in the very next cycle.
- Full mid-burst: owner 1 at beat 2, full=1 for 3 cycles with req_in[3]=1.
  - No grant while full; stall_cnt+3.
  - After full clears, owner 1 resumes beats 3 and 4, then producer 3 is granted.
  - stall_clr_in=1 then returns stall_cnt to 0.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-capable arbiter sharing one sync_fifo push port among NUM_REQ producers.
// Grants are combinational; a beat is accepted in the cycle its grant bit is high.
module fifo_push_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   output logic [NUM_REQ-1:0]            gnt_out,
   output logic                          fifo_push_req_out,
   output logic [DATA_WIDTH-1:0]         fifo_data_out,
   input  logic                          fifo_full_in,
   output logic [$clog2(NUM_REQ)-1:0]    owner_out,
   output logic                          busy_out,
   input  logic                          stall_clr_in,
   output logic [15:0]                   stall_cnt_out
);

   localparam int IW = $clog2(NUM_REQ);
   typedef logic [IW-1:0] idx_t;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t      state;
   idx_t        ptr;
   idx_t        owner;
   logic [7:0]  beat_cnt;
   logic [15:0] stall_cnt;

   logic        open;
   logic        win_vld;
   idx_t        win;
   logic        new_gnt;
   logic        cont_gnt;
   logic        gnt_vld;
   idx_t        sel;

   assign open = (state == IDLE) || !req_in[owner] || (beat_cnt == 8'(MAX_BURST));

   // First requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!win_vld && req_in[(k + 32'(ptr)) % 32'(NUM_REQ)]) begin
            win     = idx_t'((k + 32'(ptr)) % 32'(NUM_REQ));
            win_vld = 1'b1;
         end
      end
   end

   assign new_gnt  = open && win_vld && !fifo_full_in;
   assign cont_gnt = !open && !fifo_full_in;
   assign sel      = new_gnt ? win : owner;
   // Outputs are gated by rstn so an asserted reset kills a beat in the same cycle.
   assign gnt_vld  = rstn && (new_gnt || cont_gnt);

   always_comb begin
      gnt_out       = '0;
      fifo_data_out = '0;
      if (gnt_vld) begin
         gnt_out       = NUM_REQ'(1) << sel;
         fifo_data_out = data_in[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign fifo_push_req_out = gnt_vld;
   assign owner_out         = owner;
   assign busy_out          = (state == BURST);
   assign stall_cnt_out     = stall_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (new_gnt) begin
            state    <= BURST;
            owner    <= win;
            beat_cnt <= 8'd1;
            ptr      <= (win == idx_t'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end else if (cont_gnt) begin
            beat_cnt <= beat_cnt + 8'd1;
         end else if (open) begin
            state <= IDLE;
         end

         if (stall_clr_in) begin
            stall_cnt <= '0;
         end else if (|req_in && fifo_full_in && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: expected beats are queued with the stimulus
// and popped whenever the arbiter pushes into the (modelled) FIFO.
module tb_fifo_push_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_in;
   logic [63:0] data_in;
   logic [3:0]  gnt_out;
   logic        fifo_push_req_out;
   logic [15:0] fifo_data_out;
   logic        fifo_full_in;
   logic [1:0]  owner_out;
   logic        busy_out;
   logic        stall_clr_in;
   logic [15:0] stall_cnt_out;

   fifo_push_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (16),
      .MAX_BURST  (4)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .req_in            (req_in),
      .data_in           (data_in),
      .gnt_out           (gnt_out),
      .fifo_push_req_out (fifo_push_req_out),
      .fifo_data_out     (fifo_data_out),
      .fifo_full_in      (fifo_full_in),
      .owner_out         (owner_out),
      .busy_out          (busy_out),
      .stall_clr_in      (stall_clr_in),
      .stall_cnt_out     (stall_cnt_out)
   );

   typedef struct {
      int          p;
      logic [15:0] d;
   } beat_t;

   beat_t       sb[$];
   int          rem[4];
   logic [15:0] dat[4];
   logic        force_full;
   logic        count_en;
   int          fill;
   int          errors;
   int          checks;
   int          c;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int p, input logic [15:0] d);
      beat_t e;
      e.p = p;
      e.d = d;
      sb.push_back(e);
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_in[i]            = (rem[i] != 0);
         data_in[i*16 +: 16]  = dat[i];
      end
      fifo_full_in = force_full || (count_en && fill >= 16);
   endtask

   // One clock: sample at negedge, producers react just after posedge.
   task automatic cycle();
      beat_t e;
      int    g;
      logic  pushed;
      @(negedge clk);
      pushed = fifo_push_req_out;
      g = -1;
      check("no_push_when_full", {31'b0, fifo_push_req_out & fifo_full_in}, 32'd0);
      if (pushed) begin
         for (int i = 0; i < 4; i++) if (gnt_out[i]) g = i;
         if (sb.size() == 0) begin
            check("unexpected_push", {28'b0, gnt_out}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("gnt", {28'b0, gnt_out}, 32'd1 << e.p);
            check("data", {16'b0, fifo_data_out}, {16'b0, e.d});
         end
      end
      @(posedge clk);
      #1;
      if (pushed && g >= 0) begin
         if (rem[g] > 0) rem[g]--;
         dat[g]++;
         if (count_en) fill++;
      end
      drive();
   endtask

   task automatic run(input int budget, output int cyc);
      cyc = 0;
      while (sb.size() > 0 && cyc < budget) begin
         cycle();
         cyc++;
      end
      if (sb.size() != 0) begin
         check("sb_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      errors       = 0;
      checks       = 0;
      rstn         = 1'b0;
      stall_clr_in = 1'b0;
      force_full   = 1'b0;
      count_en     = 1'b0;
      fill         = 0;
      for (int i = 0; i < 4; i++) begin
         rem[i] = 0;
         dat[i] = 16'((i + 1) << 8);
      end
      drive();
      #12;
      check("rst_gnt", {28'b0, gnt_out}, 32'd0);
      check("rst_push", {31'b0, fifo_push_req_out}, 32'd0);
      check("rst_data", {16'b0, fifo_data_out}, 32'd0);
      check("rst_owner", {30'b0, owner_out}, 32'd0);
      check("rst_busy", {31'b0, busy_out}, 32'd0);
      check("rst_stall", {16'b0, stall_cnt_out}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Single producer: two back-to-back bursts of 4 with no bubble.
      rem[0] = 8;
      drive();
      for (int k = 0; k < 8; k++) push_exp(0, 16'h100 + 16'(k));
      run(20, c);
      check("single_cycles", c, 32'd8);
      check("single_busy", {31'b0, busy_out}, 32'd1);
      cycle();

      // Pointer wrap: move ptr to 2, then 1010 grants 3 before 1.
      rem[1] = 1;
      drive();
      push_exp(1, 16'h200);
      run(10, c);
      check("wrap_setup_cycles", c, 32'd1);
      cycle();
      rem[1] = 1;
      rem[3] = 1;
      drive();
      push_exp(3, 16'h400);
      push_exp(1, 16'h201);
      run(10, c);
      check("wrap_cycles", c, 32'd2);
      check("wrap_owner", {30'b0, owner_out}, 32'd1);
      cycle();

      // Early release: owner 0 drops after 2 beats, producer 2 follows at once.
      rem[3] = 1;
      drive();
      push_exp(3, 16'h401);
      run(10, c);
      cycle();
      rem[0] = 2;
      rem[2] = 2;
      drive();
      push_exp(0, 16'h108);
      push_exp(0, 16'h109);
      push_exp(2, 16'h300);
      push_exp(2, 16'h301);
      run(20, c);
      check("release_cycles", c, 32'd4);
      cycle();

      // Full mid-burst: owner 1 keeps the lock through 3 full cycles.
      rem[0] = 1;
      drive();
      push_exp(0, 16'h10A);
      run(10, c);
      cycle();
      check("stall_start", {16'b0, stall_cnt_out}, 32'd0);
      rem[1] = 4;
      drive();
      for (int k = 0; k < 4; k++) push_exp(1, 16'h202 + 16'(k));
      push_exp(3, 16'h402);
      push_exp(3, 16'h403);
      cycle();
      cycle();
      rem[3]     = 2;
      force_full = 1'b1;
      drive();
      repeat (3) cycle();
      check("full_stall_cnt", {16'b0, stall_cnt_out}, 32'd3);
      check("full_owner", {30'b0, owner_out}, 32'd1);
      check("full_busy", {31'b0, busy_out}, 32'd1);
      check("full_gnt", {28'b0, gnt_out}, 32'd0);
      force_full = 1'b0;
      drive();
      run(20, c);
      check("resume_cycles", c, 32'd4);
      cycle();
      stall_clr_in = 1'b1;
      @(posedge clk);
      #1;
      stall_clr_in = 1'b0;
      check("stall_clear", {16'b0, stall_cnt_out}, 32'd0);

      // Full rotation into a 16-deep FIFO with pops disabled.
      fill     = 0;
      count_en = 1'b1;
      for (int i = 0; i < 4; i++) rem[i] = 100;
      drive();
      for (int k = 0; k < 4; k++) push_exp(0, 16'h10B + 16'(k));
      for (int k = 0; k < 4; k++) push_exp(1, 16'h206 + 16'(k));
      for (int k = 0; k < 4; k++) push_exp(2, 16'h302 + 16'(k));
      for (int k = 0; k < 4; k++) push_exp(3, 16'h404 + 16'(k));
      run(40, c);
      check("rotation_cycles", c, 32'd16);
      repeat (5) cycle();
      check("rotation_full_gnt", {28'b0, gnt_out}, 32'd0);
      check("rotation_full_push", {31'b0, fifo_push_req_out}, 32'd0);
      check("rotation_stall_cnt", {16'b0, stall_cnt_out}, 32'd5);

      // Reset mid-burst while producer 1 owns the port.
      count_en     = 1'b0;
      fifo_full_in = 1'b0;
      req_in       = 4'hF;
      data_in      = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
      repeat (5) @(posedge clk);
      #3;
      check("pre_rst_owner", {30'b0, owner_out}, 32'd1);
      check("pre_rst_gnt", {28'b0, gnt_out}, 32'd2);
      check("pre_rst_data", {16'b0, fifo_data_out}, 32'h00D1);
      rstn = 1'b0;
      #1;
      check("mid_rst_gnt", {28'b0, gnt_out}, 32'd0);
      check("mid_rst_push", {31'b0, fifo_push_req_out}, 32'd0);
      check("mid_rst_data", {16'b0, fifo_data_out}, 32'd0);
      check("mid_rst_owner", {30'b0, owner_out}, 32'd0);
      check("mid_rst_busy", {31'b0, busy_out}, 32'd0);
      check("mid_rst_stall", {16'b0, stall_cnt_out}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("post_rst_gnt", {28'b0, gnt_out}, 32'd1);
      check("post_rst_data", {16'b0, fifo_data_out}, 32'h00D0);
      req_in = '0;
      @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
